// File: rtl/stmm_pkg.sv
// Shared types and helpers for the STMM result write-back path.
package stmm_pkg;

    // Avalon burstcount width used by the SDRAM write master.
    localparam int AVM_BURST_W = 11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_RAM = 3'd1,
        WAIT_Q = 3'd2,
        WRITE  = 3'd3,
        FIN    = 3'd4
    } stmm_wr_state_t;

    // Number of SDRAM beats needed to carry one result RAM line.
    function automatic int calc_line_n(input int bram_w, input int sdram_w);
        return (bram_w + sdram_w - 1) / sdram_w;
    endfunction

    // Byte distance between consecutive lines in SDRAM.
    function automatic int calc_stride(input int bram_w, input int sdram_w);
        return calc_line_n(bram_w, sdram_w) * sdram_w / 8;
    endfunction

endpackage

// File: rtl/stmm_line_serializer.sv
// Line buffer and beat counter: holds one result line (two with
// STMM_WR_PREFETCH_EN defined) and presents it one SDRAM beat at a time.
module stmm_line_serializer
    import stmm_pkg::*;
#(
    parameter int BRAM_W  = 1408,
    parameter int SDRAM_W = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [BRAM_W-1:0]  line_in,
    input  logic               advance,
    output logic [SDRAM_W-1:0] beat_data,
    output logic               last_beat
);

    localparam int LINE_N = calc_line_n(BRAM_W, SDRAM_W);
    localparam int BUF_W  = LINE_N * SDRAM_W;
    localparam int BEAT_W = (LINE_N > 1) ? $clog2(LINE_N) : 1;

    logic [BEAT_W-1:0] beat_q;

    assign last_beat = (beat_q == BEAT_W'(LINE_N - 1));

    // Beat index within the current line; wraps to 0 after the last beat.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            beat_q <= '0;
        end else if (advance) begin
            beat_q <= last_beat ? '0 : beat_q + BEAT_W'(1);
        end
    end

`ifdef STMM_WR_PREFETCH_EN
    logic [BUF_W-1:0] line_buf [2];
    logic             fill_ptr_q;
    logic             rd_ptr_q;

    // Capture incoming lines alternately into the two buffers.
    always_ff @(posedge clk) begin
        // NOTE: data storage is not reset; the pointers below decide what is valid.
        if (load) begin
            line_buf[fill_ptr_q] <= BUF_W'(line_in);
        end
    end

    // Fill and drain pointers ping-pong between the buffers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_ptr_q <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            if (load) begin
                fill_ptr_q <= ~fill_ptr_q;
            end
            if (advance && last_beat) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign beat_data = line_buf[rd_ptr_q][beat_q*SDRAM_W +: SDRAM_W];
`else
    logic [BUF_W-1:0] line_buf;

    // Capture the line, zero-padded up to a whole number of beats.
    always_ff @(posedge clk) begin
        // NOTE: data storage is not reset; outputs are gated until a line is loaded.
        if (load) begin
            line_buf <= BUF_W'(line_in);
        end
    end

    assign beat_data = line_buf[beat_q*SDRAM_W +: SDRAM_W];
`endif

endmodule

// File: rtl/stmm_result_writer.sv
// STMM result writer: copies num_lines result RAM lines to SDRAM, one
// Avalon-MM write burst per line. Optional macro STMM_WR_PREFETCH_EN reads
// the next line while the current one bursts, removing the inter-burst gap.
module stmm_result_writer
    import stmm_pkg::*;
#(
    parameter int BRAM_W  = 1408,
    parameter int BRAM_L  = 176,
    parameter int SDRAM_W = 128,
    parameter int RAM_LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [31:0]                 base_addr,
    input  logic [$clog2(BRAM_L+1)-1:0] num_lines,
    output logic [$clog2(BRAM_L)-1:0]   ram_addr,
    output logic                        ram_re,
    input  logic [BRAM_W-1:0]           ram_q,
    output logic [31:0]                 avm_address,
    output logic [AVM_BURST_W-1:0]      avm_burstcount,
    output logic                        avm_write,
    output logic [SDRAM_W-1:0]          avm_writedata,
    output logic [SDRAM_W/8-1:0]        avm_byteenable,
    input  logic                        avm_waitrequest,
    output logic                        busy,
    output logic                        done
);

    localparam int LINE_N = calc_line_n(BRAM_W, SDRAM_W);
    localparam int STRIDE = calc_stride(BRAM_W, SDRAM_W);
    localparam int NL_W   = $clog2(BRAM_L + 1);
    localparam int RA_W   = $clog2(BRAM_L);
    localparam int LAT_W  = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

    stmm_wr_state_t    state_q, state_d;
    logic [NL_W-1:0]   line_cnt_q, num_lines_q, num_lines_clamped, next_line;
    logic [31:0]       addr_q;
    logic              done_q;
    logic              rd_pending_q;
    logic [LAT_W-1:0]  lat_cnt_q;
    logic              start_ok, last_line, beat_accept, line_done;
    logic              rd_issue, rd_load, last_beat;
    logic [SDRAM_W-1:0] beat_data;

    assign num_lines_clamped = (num_lines > NL_W'(BRAM_L)) ? NL_W'(BRAM_L) : num_lines;
    assign start_ok    = start && (state_q == IDLE);
    assign next_line   = line_cnt_q + NL_W'(1);
    assign last_line   = (next_line == num_lines_q);
    assign beat_accept = avm_write && !avm_waitrequest;
    assign line_done   = beat_accept && last_beat;
    assign rd_load     = rd_pending_q && (lat_cnt_q == LAT_W'(RAM_LAT - 1));

`ifdef STMM_WR_PREFETCH_EN
    logic pf_ready_q, pf_issue, take_next;

    // Fetch the following line while the current one bursts, once per line.
    assign pf_issue  = (state_q == WRITE) && !rd_pending_q && !pf_ready_q && !last_line;
    assign rd_issue  = (state_q == RD_RAM) || pf_issue;
    assign ram_addr  = pf_issue ? RA_W'(next_line) : RA_W'(line_cnt_q);
    assign take_next = pf_ready_q || rd_load;

    // pf_ready_q: the idle buffer already holds the next line.
    always_ff @(posedge clk) begin
        if (rst || start_ok || line_done) begin
            pf_ready_q <= 1'b0;
        end else if (rd_load && (state_q == WRITE)) begin
            pf_ready_q <= 1'b1;
        end
    end
`else
    assign rd_issue = (state_q == RD_RAM);
    assign ram_addr = RA_W'(line_cnt_q);
`endif

    // Next-state logic for the line sequencer.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (num_lines_clamped == '0) ? FIN : RD_RAM;
                end
            end
            RD_RAM: state_d = WAIT_Q;
            WAIT_Q: begin
                if (rd_load) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (line_done) begin
                    if (last_line) begin
                        state_d = FIN;
                    end else begin
`ifdef STMM_WR_PREFETCH_EN
                        state_d = take_next ? WRITE : WAIT_Q;
`else
                        state_d = RD_RAM;
`endif
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM, job registers, line/address counters and RAM read-latency tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            line_cnt_q   <= '0;
            num_lines_q  <= '0;
            addr_q       <= '0;
            done_q       <= 1'b0;
            rd_pending_q <= 1'b0;
            lat_cnt_q    <= '0;
        end else begin
            state_q <= state_d;

            if (start_ok) begin
                addr_q      <= base_addr;
                num_lines_q <= num_lines_clamped;
                line_cnt_q  <= '0;
                done_q      <= 1'b0;
            end else if (line_done && !last_line) begin
                line_cnt_q <= next_line;
                addr_q     <= addr_q + 32'(STRIDE);
            end

            if (state_q == FIN) begin
                done_q <= 1'b1;
            end

            if (rd_issue) begin
                rd_pending_q <= 1'b1;
                lat_cnt_q    <= '0;
            end else if (rd_pending_q) begin
                if (rd_load) begin
                    rd_pending_q <= 1'b0;
                end else begin
                    lat_cnt_q <= lat_cnt_q + LAT_W'(1);
                end
            end
        end
    end

    stmm_line_serializer #(
        .BRAM_W  (BRAM_W),
        .SDRAM_W (SDRAM_W)
    ) u_serializer (
        .clk       (clk),
        .rst       (rst),
        .load      (rd_load),
        .line_in   (ram_q),
        .advance   (beat_accept),
        .beat_data (beat_data),
        .last_beat (last_beat)
    );

    assign ram_re         = rd_issue;
    assign avm_write      = (state_q == WRITE);
    assign avm_address    = addr_q;
    assign avm_burstcount = avm_write ? AVM_BURST_W'(LINE_N) : '0;
    assign avm_writedata  = avm_write ? beat_data : '0;
    assign avm_byteenable = '1;
    assign busy           = (state_q != IDLE);
    assign done           = done_q;

endmodule

// File: tb/tb_stmm_result_writer.sv
// Directed bench for stmm_result_writer: RAM model, Avalon slave with
// optional random stalls, beat monitor and per-beat comparison.
module tb_stmm_result_writer;

    localparam int BRAM_W  = 1408;
    localparam int BRAM_L  = 176;
    localparam int SDRAM_W = 128;
    localparam int RAM_LAT = 1;
    localparam int LINE_N  = 11;
    localparam int STRIDE  = 176;
`ifdef STMM_WR_PREFETCH_EN
    localparam int GAP = 0;
`else
    localparam int GAP = 1 + RAM_LAT;
`endif

    logic                clk;
    logic                rst;
    logic                start;
    logic [31:0]         base_addr;
    logic [7:0]          num_lines;
    logic [7:0]          ram_addr;
    logic                ram_re;
    logic [BRAM_W-1:0]   ram_q;
    logic [31:0]         avm_address;
    logic [10:0]         avm_burstcount;
    logic                avm_write;
    logic [SDRAM_W-1:0]  avm_writedata;
    logic [15:0]         avm_byteenable;
    logic                avm_waitrequest;
    logic                busy;
    logic                done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit stall_en = 1'b0;

    stmm_result_writer #(
        .BRAM_W  (BRAM_W),
        .BRAM_L  (BRAM_L),
        .SDRAM_W (SDRAM_W),
        .RAM_LAT (RAM_LAT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .base_addr       (base_addr),
        .num_lines       (num_lines),
        .ram_addr        (ram_addr),
        .ram_re          (ram_re),
        .ram_q           (ram_q),
        .avm_address     (avm_address),
        .avm_burstcount  (avm_burstcount),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Distinct content per line and per 32-bit word.
    function automatic logic [BRAM_W-1:0] pat(input int i);
        logic [BRAM_W-1:0] v;
        v = '0;
        for (int j = 0; j < BRAM_W / 32; j++) begin
            v[j*32 +: 32] = {i[7:0], j[7:0], 8'hC3, 8'(i * 7 + j)};
        end
        return v;
    endfunction

    // Result RAM model, one cycle read latency.
    always @(posedge clk) begin
        if (ram_re) ram_q <= pat(int'(ram_addr));
    end

    // Avalon slave stall generator.
    initial begin
        avm_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            avm_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Beat monitor.
    logic [31:0]        beat_addr_q [$];
    logic [10:0]        beat_bc_q   [$];
    logic [SDRAM_W-1:0] beat_data_q [$];
    int                 beat_cyc_q  [$];
    int                 ram_re_cnt = 0;
    int                 stall_chk  = 0;
    int                 stall_err  = 0;
    bit                 prev_stall = 1'b0;
    logic [31:0]        p_addr;
    logic [10:0]        p_bc;
    logic [SDRAM_W-1:0] p_data;

    always @(negedge clk) begin
        if (ram_re) ram_re_cnt++;
        if (avm_write) begin
            if (prev_stall) begin
                stall_chk++;
                if (avm_address !== p_addr || avm_burstcount !== p_bc || avm_writedata !== p_data)
                    stall_err++;
            end
            if (!avm_waitrequest) begin
                beat_addr_q.push_back(avm_address);
                beat_bc_q.push_back(avm_burstcount);
                beat_data_q.push_back(avm_writedata);
                beat_cyc_q.push_back(cyc);
            end
        end else if (prev_stall) begin
            stall_err++;
        end
        prev_stall = avm_write && avm_waitrequest;
        p_addr = avm_address;
        p_bc   = avm_burstcount;
        p_data = avm_writedata;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    int t_start;
    int idx0;

    task automatic start_job(input logic [31:0] base, input logic [7:0] n);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = base;
        num_lines = n;
        t_start   = cyc;
        idx0      = beat_addr_q.size();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        bit found;
        found = 1'b0;
        dc = -1;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                dc = cyc;
            end
        end
        if (!found) check("done_timeout", done, 1);
    endtask

    task automatic check_job(input int first, input logic [31:0] base, input int n);
        int cnt;
        int l;
        int b;
        logic [BRAM_W-1:0] ln;
        cnt = beat_addr_q.size() - first;
        check("beat_count", cnt, n * LINE_N);
        for (int k = 0; k < cnt && k < n * LINE_N; k++) begin
            l  = k / LINE_N;
            b  = k % LINE_N;
            ln = pat(l);
            check("beat_addr", beat_addr_q[first+k], base + 32'(l * STRIDE));
            check("beat_burstcount", beat_bc_q[first+k], 11);
            check("beat_data", beat_data_q[first+k], ln[b*SDRAM_W +: SDRAM_W]);
        end
    endtask

    initial begin
        int dc;
        int re0;
        int nb0;
        logic [BRAM_W-1:0] ln;

        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        num_lines = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state
        check("rst_avm_write", avm_write, 0);
        check("rst_ram_re", ram_re, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_avm_address", avm_address, 0);
        check("rst_burstcount", avm_burstcount, 0);
        check("rst_writedata", avm_writedata, 0);
        check("rst_byteenable", avm_byteenable, 16'hFFFF);
        rst = 1'b0;

        // One line at 0x1000, no stalls
        start_job(32'h1000, 8'd1);
        wait_done(dc);
        check("t1_done_cycle", dc - t_start, 15);
        check_job(idx0, 32'h1000, 1);
        if (beat_addr_q.size() >= idx0 + LINE_N) begin
            ln = pat(0);
            check("t1_first_write_cycle", beat_cyc_q[idx0] - t_start, 2 + RAM_LAT);
            check("t1_addr", beat_addr_q[idx0], 32'h1000);
            check("t1_beat0", beat_data_q[idx0], ln[127:0]);
            check("t1_beat10", beat_data_q[idx0+10], ln[1407:1280]);
        end

        // Three lines at 0x2000 with an ignored start while busy
        start_job(32'h2000, 8'd3);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = 32'h9000;
        num_lines = 8'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(dc);
        check("t2_done_cycle", dc - t_start, 2 + RAM_LAT + 3 * LINE_N + 2 * GAP + 1);
        check_job(idx0, 32'h2000, 3);
        if (beat_addr_q.size() >= idx0 + 3 * LINE_N) begin
            check("t2_line0_addr", beat_addr_q[idx0], 32'h2000);
            check("t2_line1_addr", beat_addr_q[idx0+11], 32'h20B0);
            check("t2_line2_addr", beat_addr_q[idx0+22], 32'h2160);
        end

        // Four lines with random stalls
        stall_en = 1'b1;
        start_job(32'h3000, 8'd4);
        wait_done(dc);
        stall_en = 1'b0;
        check_job(idx0, 32'h3000, 4);
        check("t3_stalls_seen", stall_chk > 0, 1);
        check("t3_stall_stability", stall_err, 0);

        // Zero lines; second start while in FIN ignored
        @(posedge clk);
        re0 = ram_re_cnt;
        start_job(32'h6000, 8'd0);
        start = 1'b1;
        base_addr = 32'h7000;
        num_lines = 8'd3;
        @(negedge clk);
        check("t4_done_cleared", done, 0);
        check("t4_busy_fin", busy, 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("t4_done_t2", done, 1);
        check("t4_idle_t2", busy, 0);
        repeat (20) @(negedge clk);
        check("t4_no_beats", beat_addr_q.size() - idx0, 0);
        check("t4_no_ram_re", ram_re_cnt - re0, 0);
        check("t4_done_sticky", done, 1);
        check("t4_still_idle", busy, 0);

        // Reset during beat 5 of line 1
        start_job(32'h5000, 8'd3);
        for (int i = 0; i < 200 && cyc != t_start + 19 + GAP; i++) @(negedge clk);
        ln = pat(1);
        check("t5_pre_write", avm_write, 1);
        check("t5_pre_addr", avm_address, 32'h50B0);
        check("t5_pre_data", avm_writedata, ln[5*SDRAM_W +: SDRAM_W]);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t5_rst_write", avm_write, 0);
        check("t5_rst_ram_re", ram_re, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_addr", avm_address, 0);
        check("t5_rst_burstcount", avm_burstcount, 0);
        check("t5_rst_writedata", avm_writedata, 0);
        rst = 1'b0;

        // Fresh two-line job from base 0 after reset
        nb0 = beat_addr_q.size();
        start_job(32'h0, 8'd2);
        check("t6_no_stray_beats", idx0 - nb0, 0);
        wait_done(dc);
        check("t6_done_cycle", dc - t_start, 2 + RAM_LAT + 2 * LINE_N + GAP + 1);
        check_job(idx0, 32'h0, 2);
        if (beat_addr_q.size() >= idx0 + 2 * LINE_N)
            check("t6_burst_gap", beat_cyc_q[idx0+11] - beat_cyc_q[idx0+10], 1 + GAP);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/stmm_result_writer.md
Name: stmm_result_writer

Overview:
Write-back counterpart of the STMM parameter fetcher. On `start` it reads `num_lines` lines of `BRAM_W` bits from the STMM result BRAM. Each line is split into `SDRAM_W`-bit beats and written to SDRAM as one Avalon-MM write burst per line. The block sits between the STMM result RAM and the SDRAM write master port, and raises a sticky `done` on completion.

Parameters:
BRAM_W, 1408, result RAM line width (bits)
BRAM_L, 176, result RAM depth (lines)
SDRAM_W, 128, Avalon data width (bits)
RAM_LAT, 1, result RAM read latency in cycles (1 or 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  1-cycle pulse; accepted only in IDLE
base_addr  in  32  SDRAM byte address of line 0
num_lines  in  $clog2(BRAM_L+1)  lines to write; values >BRAM_L clamp to BRAM_L
ram_addr  out  $clog2(BRAM_L)  result RAM read address
ram_re  out  1  result RAM read enable
ram_q  in  BRAM_W  result RAM read data, valid RAM_LAT cycles after ram_re
avm_address  out  32  burst start byte address
avm_burstcount  out  11  beats per burst (=LINE_N)
avm_write  out  1  write request
avm_writedata  out  SDRAM_W  beat data
avm_byteenable  out  SDRAM_W/8  all ones
avm_waitrequest  in  1  slave stall
busy  out  1  high outside IDLE
done  out  1  sticky completion flag

Behaviour:
- Constants: LINE_N = ceil(BRAM_W/SDRAM_W) (11 at defaults); STRIDE = LINE_N*SDRAM_W/8 bytes (176).
- Reset values: every output 0 (`avm_byteenable` is constant all ones); `state` = IDLE; counters 0.
- `start` in IDLE:
  - latches `base_addr` and the clamped `num_lines`;
  - clears `done`;
  - sets line_cnt=0.
  - `start` outside IDLE is ignored.
- States:
  - IDLE → RD_RAM on start, or → FIN if `num_lines` = 0.
  - RD_RAM: one cycle with `ram_re`=1 and `ram_addr`=line_cnt → WAIT_Q.
  - WAIT_Q: RAM_LAT cycles. On the last one, `ram_q` is captured into the line buffer, zero-padded to LINE_N*SDRAM_W → WRITE.
  - WRITE: `avm_write`=1 with `avm_writedata` = buffer slice [beat*SDRAM_W +: SDRAM_W].
    - `avm_address` = base + line_cnt*STRIDE and `avm_burstcount` = LINE_N are held constant for the whole burst.
    - A beat is accepted when `avm_write` && !`avm_waitrequest`; beat increments on acceptance.
    - While waitrequest is high, address, data and burstcount stay stable.
    - On acceptance of beat LINE_N-1: line_cnt++ and beat=0. If line_cnt+1 == num_lines → FIN, else → RD_RAM.
  - FIN: `done` set for one cycle → IDLE. `done` then stays high until the next accepted start or reset.
- Latency: the first `avm_write` is asserted 2+RAM_LAT cycles after the start cycle (cycle T+3 for RAM_LAT=1) when waitrequest is low.
- Gap between bursts (no prefetch): 1+RAM_LAT idle cycles.
- Address arithmetic: 32-bit, wraps modulo 2^32 without error.
- Reset mid-burst: all state is dropped on that edge and `avm_write` is 0 the next cycle. The partial burst is abandoned; system reset covers the slave.
- `busy` = (state != IDLE).

Optional Feature:
- Macro: STMM_WR_PREFETCH_EN.
- Defined:
  - Adds a second line buffer.
  - While line k bursts, line k+1 is read from RAM (RD_RAM/WAIT_Q run concurrently with WRITE).
  - The next burst starts in the cycle after the last beat of line k is accepted: zero idle gap when waitrequest is low.
  - Total cycles for N lines with no stall = 2+RAM_LAT + N*LINE_N + 1.
- Undefined: single buffer; sequencing exactly as above.

Decomposition:
- Package stmm_pkg:
  - `stmm_wr_state_t` enum {IDLE, RD_RAM, WAIT_Q, WRITE, FIN};
  - `LINE_N`/`STRIDE` helper functions of (BRAM_W, SDRAM_W);
  - AVM_BURST_W = 11.
- Sub-module stmm_line_serializer:
  - holds the line buffer(s) and beat counter;
  - ports: load, line_in, advance, beat_data, last_beat.
- The top holds the FSM, line counter and address generation.

Test Plan:
- num_lines=1, base=0x1000, no waitrequest:
  - 11 beats at address 0x1000, burstcount 11;
  - beat 0 = ram_q[127:0], beat 10 = ram_q[1407:1280];
  - `done` high at T+15.
- num_lines=3, base=0x2000, RAM line i = pattern i: three bursts at 0x2000, 0x20B0 and 0x2160 with correct data.
- Random waitrequest (50%), num_lines=4: the monitor checks address, data and burstcount stable while stalled, exactly 44 accepted beats and no dropped beats.
- num_lines=0: no `avm_write`, `ram_re` never high, `done`=1 two cycles after start. A second start while busy is ignored.
- Reset asserted at beat 5 of line 1: outputs are 0 the next cycle. A fresh start with base=0x0 then writes cleanly from line 0.
- STMM_WR_PREFETCH_EN, num_lines=2, no stall: 22 beats contiguous with no gap; total 26 cycles start→done.
